// File: rtl/if_id_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch / IF-ID pipeline slice.
// Widths, reset values and the canonical NOP live here so every stage agrees on them.
package if_id_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET        = 64'h0000_0000_0000_0000;
    localparam logic [XLEN-1:0] PC_STEP         = 64'h0000_0000_0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0]     FETCH_COUNT_MAX = 32'hFFFF_FFFF;

    // Redirect targets are word-aligned by dropping the two low address bits.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return target & PC_ALIGN_MASK;
    endfunction

    // Saturating increment used by the fetch counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == FETCH_COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter register with its next-PC selection.
// Priority is reset, then redirect, then stall hold, then sequential step.
module pc_reg
    import if_id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    // Next-PC selection: redirect beats stall; the sequential step wraps modulo 2^64.
    always_comb begin
        w_pc_next = r_pc;
        if (flush) begin
            w_pc_next = align_target(branch_target);
        end else if (stall) begin
            w_pc_next = r_pc;
        end else begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    // PC state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: drives the PC to instruction memory and latches the returned word
// into the IF/ID register one cycle later, counting every live instruction latched.
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic [31:0]     fetch_count
);

    logic [XLEN-1:0] w_pc;
    logic            w_load;

    logic [XLEN-1:0] r_if_id_pc;
    logic [ILEN-1:0] r_if_id_instr;
    logic            r_if_id_valid;
    logic [31:0]     r_fetch_count;

    pc_reg u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .pc            (w_pc)
    );

    // A live instruction enters IF/ID only when neither squashed nor frozen.
    always_comb begin
        w_load = 1'b0;
        if (flush) begin
            w_load = 1'b0;
        end else if (stall) begin
            w_load = 1'b0;
        end else begin
            w_load = 1'b1;
        end
    end

    // IF/ID pipeline register: squash to NOP on redirect, hold on stall, else capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_pc    <= PC_RESET;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (flush) begin
            r_if_id_pc    <= PC_RESET;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (stall) begin
            r_if_id_pc    <= r_if_id_pc;
            r_if_id_instr <= r_if_id_instr;
            r_if_id_valid <= r_if_id_valid;
        end else begin
            r_if_id_pc    <= w_pc;
            r_if_id_instr <= imem_rdata;
            r_if_id_valid <= 1'b1;
        end
    end

    // Saturating count of live instructions latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_load) begin
            r_fetch_count <= sat_inc32(r_fetch_count);
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign imem_addr   = w_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural fetch model.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PROG [4] = '{32'h0010_0003, 32'h0011_2023, 32'h0020_8063, 32'h0051_8283};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic [31:0] imem_rdata;
    logic [63:0] imem_addr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        use_prog = 1'b0;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [63:0] m_pc = 64'h0;
    logic [63:0] m_ifpc = 64'h0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = 32'h0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] addr, input logic prog);
        logic [31:0] w;
        if (prog && addr < 64'd16) w = PROG[addr[3:2]];
        else w = (addr[31:0] * 32'h9E37_79B1) ^ addr[63:32] ^ 32'h1234_5678;
        return w;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr, use_prog);

    // Apply inputs for one cycle, advance the model, then sample after the edge.
    task automatic tick(input logic r, input logic s, input logic f, input logic [63:0] t);
        reset = r; stall = s; flush = f; branch_target = t;
        if (r) begin
            m_pc = 64'h0; m_ifpc = 64'h0; m_instr = NOP; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (f) begin
            m_ifpc = 64'h0; m_instr = NOP; m_valid = 1'b0;
            m_pc = (t / 64'd4) * 64'd4;
        end else if (!s) begin
            m_instr = mem_word(m_pc, use_prog); m_ifpc = m_pc; m_valid = 1'b1;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 64'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1, 64'h777);
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
        checks++; if (if_id_pc !== 64'h0) begin failures++; $display("FAIL reset_ifpc got=%h exp=0", if_id_pc); end
        checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, NOP); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    endtask

    task automatic test_sequential();
        use_prog = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 64'h0);
            checks++; if (if_id_pc !== 64'(i * 4)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, if_id_pc, 64'(i * 4)); end
            checks++; if (if_id_instr !== PROG[i]) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, if_id_instr, PROG[i]); end
            checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, if_id_valid); end
            checks++; if (imem_addr !== 64'(i * 4 + 4)) begin failures++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, imem_addr, 64'(i * 4 + 4)); end
        end
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
        use_prog = 1'b0;
    endtask

    task automatic test_stall();
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 64'h0);
            checks++; if (imem_addr !== 64'h8) begin failures++; $display("FAIL stall_addr got=%h exp=8", imem_addr); end
            checks++; if (if_id_pc !== 64'h4) begin failures++; $display("FAIL stall_ifpc got=%h exp=4", if_id_pc); end
            checks++; if (if_id_instr !== mem_word(64'h4, 1'b0)) begin failures++; $display("FAIL stall_instr got=%h exp=%h", if_id_instr, mem_word(64'h4, 1'b0)); end
            checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", fetch_count); end
        end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (if_id_pc !== 64'h8) begin failures++; $display("FAIL stall_release_pc got=%h exp=8", if_id_pc); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_release_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_flush();
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (imem_addr !== 64'h10) begin failures++; $display("FAIL flush_pre_addr got=%h exp=10", imem_addr); end
        tick(1'b0, 1'b0, 1'b1, 64'h103);
        checks++; if (if_id_instr !== NOP) begin failures++; $display("FAIL flush_instr got=%h exp=%h", if_id_instr, NOP); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", if_id_valid); end
        checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL flush_addr got=%h exp=100", imem_addr); end
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL flush_count got=%0d exp=4", fetch_count); end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (if_id_pc !== 64'h100 || if_id_valid !== 1'b1) begin failures++; $display("FAIL flush_target_latch got=%h/%b exp=100/1", if_id_pc, if_id_valid); end
    endtask

    task automatic test_stall_flush();
        tick(1'b0, 1'b1, 1'b1, 64'h40);
        checks++; if (imem_addr !== 64'h40) begin failures++; $display("FAIL sf_addr got=%h exp=40", imem_addr); end
        checks++; if (if_id_instr !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 64'h0) begin failures++; $display("FAIL sf_ifid got=%h/%h/%b exp=0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL sf_count got=%0d exp=5", fetch_count); end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0, 1'b1, 64'h200);
        tick(1'b0, 1'b0, 1'b1, 64'h302);
        checks++; if (imem_addr !== 64'h300) begin failures++; $display("FAIL b2b_addr got=%h exp=300", imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (if_id_pc !== 64'h300 || if_id_instr !== mem_word(64'h300, 1'b0)) begin failures++; $display("FAIL b2b_latch got=%h/%h exp=300/%h", if_id_pc, if_id_instr, mem_word(64'h300, 1'b0)); end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_redirect got=%h exp=fffffffffffffffc", imem_addr); end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
        checks++; if (if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_valid !== 1'b1) begin failures++; $display("FAIL wrap_ifid got=%h/%b exp=fffffffffffffffc/1", if_id_pc, if_id_valid); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (imem_addr !== 64'h24) begin failures++; $display("FAIL mid_pre_addr got=%h exp=24", imem_addr); end
        tick(1'b1, 1'b0, 1'b1, 64'h500);
        checks++; if (imem_addr !== 64'h0 || if_id_pc !== 64'h0 || if_id_instr !== NOP || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin
            failures++; $display("FAIL mid_reset got=%h/%h/%h/%b/%0d exp=0/0/%h/0/0", imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, NOP);
        end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (if_id_pc !== 64'h0 || if_id_instr !== mem_word(64'h0, 1'b0) || if_id_valid !== 1'b1 || imem_addr !== 64'h4) begin
            failures++; $display("FAIL mid_first_fetch got=%h/%h/%b/%h exp=0/%h/1/4", if_id_pc, if_id_instr, if_id_valid, imem_addr, mem_word(64'h0, 1'b0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(99) < 3, $urandom_range(99) < 25, $urandom_range(99) < 12, {$urandom, $urandom});
            checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, imem_addr, m_pc); end
            checks++; if (if_id_pc !== m_ifpc) begin failures++; $display("FAIL rnd_ifpc[%0d] got=%h exp=%h", i, if_id_pc, m_ifpc); end
            checks++; if (if_id_instr !== m_instr) begin failures++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, if_id_instr, m_instr); end
            checks++; if (if_id_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, if_id_valid, m_valid); end
            checks++; if (fetch_count !== m_cnt) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, fetch_count, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_stall_flush();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 stall  input  1  from hazard unit (load-use); freezes PC and IF/ID register.
REQ-004 flush  input  1  taken branch/jump resolved downstream; squashes the fetched instruction.
REQ-005 branch_target  input  64  redirect address, used when flush=1.
REQ-006 imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-007 imem_addr  output  64  current PC driven to instruction memory.
REQ-008 if_id_pc  output  64  PC of the latched instruction.
REQ-009 if_id_instr  output  32  latched instruction; feeds decoder and immediate generator.
REQ-010 if_id_valid  output  1  latched instruction is architecturally live.
REQ-011 fetch_count  output  32  number of instructions latched with valid=1.

Function
REQ-012 imem_addr SHALL equal the PC register combinationally, with no added latency.
REQ-013 PC update priority SHALL be reset > flush > stall > sequential.
REQ-014 flush=1: PC <= {branch_target[63:2],2'b00}; low two target bits forced to zero.
REQ-015 stall=1, flush=0: PC holds its value.
REQ-016 Otherwise PC <= PC+4, modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC wraps to 0x0.
REQ-017 IF/ID register, flush=1: if_id_instr <= 32'h0000_0013 (NOP), if_id_pc <= 0, if_id_valid <= 0.
REQ-018 IF/ID register, stall=1, flush=0: all three fields hold.
REQ-019 IF/ID register, otherwise: if_id_instr <= imem_rdata, if_id_pc <= PC, if_id_valid <= 1.
REQ-020 Fetch-to-decode latency SHALL be one cycle: the word at PC in cycle N appears on if_id_instr in cycle N+1.
REQ-021 Simultaneous stall and flush: flush wins for both PC and IF/ID; no instruction is lost, because the squashed slot is wrong-path.
REQ-022 Back-to-back flushes: each redirect takes effect, and the last one fetches first.
REQ-023 fetch_count SHALL increment by 1 on each edge where the IF/ID register loads with valid=1, saturating at 0xFFFF_FFFF.
REQ-024 Stalled or flushed cycles SHALL NOT increment fetch_count.
REQ-025 Outputs SHALL contain no X after the first reset edge, whatever the stall/flush values.

Reset
REQ-026 On reset: PC=0x0, if_id_pc=0x0, if_id_instr=32'h0000_0013, if_id_valid=0, fetch_count=0.
REQ-027 Reset SHALL override stall and flush on the same edge.
REQ-028 Reset asserted mid-stream SHALL discard any pending redirect; the first post-reset fetch comes from 0x0.
REQ-029 Reset deasserted: the first edge latches the word at 0x0 with valid=1, and PC becomes 0x4.

Structure
REQ-030 A shared package SHALL hold NOP_INSTR (32'h0000_0013), PC_RESET (64'h0), XLEN=64, ILEN=32 and PC_STEP=4.
REQ-031 The PC register and next-PC mux SHALL be a sub-module pc_reg (inputs clk, reset, stall, flush, branch_target; output pc).
REQ-032 The IF/ID latch and fetch_count SHALL live in if_id_stage.

Verification
REQ-033 Sequential fetch: reset 2 cycles, then run 4 cycles with memory returning 0x00100003, 0x00112023, 0x00208063, 0x00518283 → if_id_pc 0,4,8,12 in order, each with the matching instruction, valid=1, fetch_count=4.
REQ-034 Stall: stall=1 for 2 cycles at PC=0x8 → imem_addr stays 0x8 and the IF/ID fields hold; after release the next if_id_pc is 0x8, and fetch_count does not advance during the stall.
REQ-035 Flush: flush=1 with branch_target=0x103 at PC=0x10 → next if_id_instr=0x00000013 and valid=0; the PC becomes 0x100, and the following cycle latches pc=0x100.
REQ-036 Stall and flush together: stall=1, flush=1, target=0x40 → PC=0x40, IF/ID holds NOP, valid=0.
REQ-037 Wrap: force a redirect to 0xFFFF_FFFF_FFFF_FFFC → next PC=0x0, and if_id_pc=0xFFFF_FFFF_FFFF_FFFC with valid=1.
REQ-038 Reset mid-operation: assert reset while PC=0x24 and flush=1 → all outputs take the REQ-026 values, and the first fetch after release is from 0x0.
